// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state encoding and access-size helper
// for the data-memory load/store sequencer.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, FAULT, LOAD, WRITE, RMW_RD, RMW_WR} state_t;

    // Access size in bytes from funct3; the unsigned variants share the low bits.
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: core request/response and data-memory bus bundle.
// Ports (slave = sequencer view):
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : core request
//   resp_valid/resp_rdata/resp_fault                            : core response
//   mem_address/mem_read/mem_write/mem_wdata/mem_rdata          : word memory
interface dmem_access_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_fault;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_read, mem_write, mem_wdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for sub-word accesses.
// Ports:
//   word_i   : word read from memory
//   wdata_i  : right-justified store data
//   off_i    : byte offset within the word
//   funct3_i : RV32I load/store funct3
//   load_o   : extracted and sign/zero-extended load data
//   merge_o  : word_i with the store bytes replaced at off_i
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  sh;
    logic [15:0] lane;
    logic [31:0] mask;

    always_comb begin
        sh      = {off_i, 3'b000};
        lane    = 16'(word_i >> sh);
        load_o  = funct3_i == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                  funct3_i == F3_BU ? {24'b0, lane[7:0]} :
                  funct3_i == F3_H  ? {{16{lane[15]}}, lane} :
                  funct3_i == F3_HU ? {16'b0, lane} : word_i;
        mask    = (funct3_i[1:0] == 2'b00 ? 32'h0000_00FF :
                   funct3_i[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
        merge_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: RV32I load/store sequencer for a word-only data memory,
// with read-modify-write for SB/SH and fault rejection of bad requests.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_access_ctrl_if.slave (core request/response + memory bus)
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int            AW   = 32,
    parameter int            DW   = 32,
    parameter logic [AW-1:0] BASE = 'h1000,
    parameter int            SIZE = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_access_ctrl_if.slave  bus
);

    localparam logic [AW:0] LIMIT = {1'b0, BASE} + (AW+1)'(SIZE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [2:0]    funct3_q;
    logic [DW-1:0] wdata_q, buf_q, resp_rdata_q;
    logic          resp_valid_q, resp_fault_q;
    logic          accept, illegal, misaligned, out_of_range, fault;
    logic [2:0]    size;
    logic [AW:0]   last_byte;
    logic [DW-1:0] load_data, merge_data;

    always_comb begin
        accept       = bus.req_valid && state_q == IDLE;
        size         = size_of(bus.req_funct3);
        illegal      = bus.req_write ? bus.req_funct3[2] || bus.req_funct3 == 3'b011
                                     : bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11;
        misaligned   = (size == 3'd2 && bus.req_addr[0]) || (size == 3'd4 && bus.req_addr[1:0] != 2'b00);
        last_byte    = {1'b0, bus.req_addr} + (AW+1)'(size) - (AW+1)'(1);
        out_of_range = bus.req_addr < BASE || last_byte > LIMIT;
        fault        = illegal || misaligned || out_of_range;
        state_d      = state_q == RMW_RD ? RMW_WR :
                       state_q != IDLE   ? IDLE :
                       !accept           ? IDLE :
                       fault             ? FAULT :
                       !bus.req_write    ? LOAD :
                       bus.req_funct3 == F3_W ? WRITE : RMW_RD;
    end

    dmem_lane_align u_align (
        .word_i   (bus.mem_rdata),
        .wdata_i  (wdata_q),
        .off_i    (addr_q[1:0]),
        .funct3_i (funct3_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    // Fault responses are registered on the accept edge, so they surface
    // during the FAULT cycle; all others surface in the IDLE cycle that follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= bus.req_addr;
                funct3_q <= bus.req_funct3;
                wdata_q  <= bus.req_wdata;
            end
            if (state_q == RMW_RD) buf_q <= merge_data;
            resp_valid_q <= (accept && fault) || state_q inside {LOAD, WRITE, RMW_WR};
            resp_fault_q <= accept && fault;
            resp_rdata_q <= state_q == LOAD ? load_data : '0;
        end
    end

    assign bus.req_ready   = state_q == IDLE;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_fault  = resp_fault_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.mem_address = {addr_q[AW-1:2], 2'b00};
    assign bus.mem_read    = state_q == LOAD || state_q == RMW_RD;
    assign bus.mem_write   = state_q == WRITE || state_q == RMW_WR;
    assign bus.mem_wdata   = state_q == WRITE ? wdata_q : state_q == RMW_WR ? buf_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed self-checking bench for dmem_access_ctrl
// with a behavioural word memory (combinational read, clocked write).
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic clk, rst_n;
    int checks = 0, errors = 0;
    int r_lat, r_nrd, r_nwr, r_nbusy;
    logic [31:0] r_rd, r_wd;
    logic r_flt, r_rdy;
    logic [31:0] mem [256];

    dmem_access_ctrl_if #(.AW(32), .DW(32)) bus();

    dmem_access_ctrl #(.AW(32), .DW(32), .BASE(32'h1000), .SIZE(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_address[9:2]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_wdata;

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4 && !bus.req_ready; i++) begin
            @(posedge clk); #1;
        end
        r_rdy = bus.req_ready;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        r_lat = 1; r_nrd = 0; r_nwr = 0; r_nbusy = 0; r_wd = '0; r_rd = 'x; r_flt = 1'bx;
        for (int i = 0; i < 8; i++) begin
            r_nrd += int'(bus.mem_read);
            r_nwr += int'(bus.mem_write);
            if (bus.mem_write) r_wd = bus.mem_wdata;
            if (bus.resp_valid) begin
                r_rd = bus.resp_rdata; r_flt = bus.resp_fault;
                break;
            end
            r_nbusy += int'(bus.req_ready);
            @(posedge clk); #1;
            r_lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
        #12;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_fault !== 1'b0) begin errors++; $display("FAIL reset_resp_fault got %b want 0", bus.resp_fault); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        logic [2:0]  f3 [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
        logic [31:0] ad [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
        logic [31:0] ex [5] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB, 32'h8899_AABB};
        issue(1'b1, F3_W, 32'h1000, 32'h8899_AABB);
        checks++; if (r_flt !== 1'b0 || r_lat != 2) begin errors++; $display("FAIL sw_init got fault=%b lat=%0d want 0 2", r_flt, r_lat); end
        checks++; if (r_nwr != 1 || r_wd !== 32'h8899_AABB) begin errors++; $display("FAIL sw_init_write got n=%0d data=%h want 1 8899aabb", r_nwr, r_wd); end
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3[i], ad[i], 32'h0);
            checks++; if (r_rd !== ex[i]) begin errors++; $display("FAIL load_rdata[%0d] got %h want %h", i, r_rd, ex[i]); end
            checks++; if (r_flt !== 1'b0) begin errors++; $display("FAIL load_fault[%0d] got %b want 0", i, r_flt); end
            checks++; if (r_lat != 2) begin errors++; $display("FAIL load_latency[%0d] got %0d want 2", i, r_lat); end
            checks++; if (r_nrd != 1 || r_nwr != 0) begin errors++; $display("FAIL load_strobes[%0d] got rd=%0d wr=%0d want 1 0", i, r_nrd, r_nwr); end
        end
    endtask

    task automatic test_rmw_store;
        issue(1'b1, F3_B, 32'h1001, 32'h1234_565C);
        checks++; if (r_nwr != 1 || r_wd !== 32'h8899_5CBB) begin errors++; $display("FAIL sb_write got n=%0d data=%h want 1 88995cbb", r_nwr, r_wd); end
        checks++; if (r_lat != 3 || r_flt !== 1'b0 || r_rd !== 32'h0) begin errors++; $display("FAIL sb_resp got lat=%0d fault=%b rdata=%h want 3 0 0", r_lat, r_flt, r_rd); end
        checks++; if (r_nrd != 1) begin errors++; $display("FAIL sb_reads got %0d want 1", r_nrd); end
        issue(1'b0, F3_W, 32'h1000, 32'h0);
        checks++; if (r_rd !== 32'h8899_5CBB) begin errors++; $display("FAIL sb_readback got %h want 88995cbb", r_rd); end
        issue(1'b1, F3_H, 32'h1002, 32'hFFFF_BEEF);
        checks++; if (r_nwr != 1 || r_wd !== 32'hBEEF_5CBB || r_lat != 3) begin errors++; $display("FAIL sh_write got n=%0d data=%h lat=%0d want 1 beef5cbb 3", r_nwr, r_wd, r_lat); end
        issue(1'b0, F3_HU, 32'h1002, 32'h0);
        checks++; if (r_rd !== 32'h0000_BEEF) begin errors++; $display("FAIL sh_readback got %h want 0000beef", r_rd); end
    endtask

    task automatic test_fault;
        logic        wr [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3 [9] = '{F3_H, F3_W, F3_W, F3_W, 3'b011, 3'b100, 3'b110, F3_H, F3_B};
        logic [31:0] ad [9] = '{32'h1001, 32'h1002, 32'h1400, 32'h0FFC, 32'h1000, 32'h1000, 32'h1000, 32'h13FF, 32'h0FFF};
        for (int i = 0; i < 9; i++) begin
            issue(wr[i], f3[i], ad[i], 32'hBAD0_BAD0);
            checks++; if (r_flt !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL fault_resp[%0d] got fault=%b rdata=%h want 1 0", i, r_flt, r_rd); end
            checks++; if (r_lat != 1) begin errors++; $display("FAIL fault_latency[%0d] got %0d want 1", i, r_lat); end
            checks++; if (r_nrd != 0 || r_nwr != 0) begin errors++; $display("FAIL fault_strobes[%0d] got rd=%0d wr=%0d want 0 0", i, r_nrd, r_nwr); end
        end
        issue(1'b0, F3_W, 32'h1000, 32'h0);
        checks++; if (r_rd !== 32'hBEEF_5CBB || r_flt !== 1'b0) begin errors++; $display("FAIL fault_mem_intact got %h fault=%b want beef5cbb 0", r_rd, r_flt); end
    endtask

    task automatic test_boundary;
        issue(1'b1, F3_W, 32'h13FC, 32'hDEAD_BEEF);
        checks++; if (r_flt !== 1'b0 || r_nwr != 1 || r_lat != 2) begin errors++; $display("FAIL sw_top got fault=%b n=%0d lat=%0d want 0 1 2", r_flt, r_nwr, r_lat); end
        issue(1'b0, F3_W, 32'h13FC, 32'h0);
        checks++; if (r_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_top got %h want deadbeef", r_rd); end
        issue(1'b0, F3_B, 32'h13FF, 32'h0);
        checks++; if (r_rd !== 32'hFFFF_FFDE || r_flt !== 1'b0) begin errors++; $display("FAIL lb_last got %h fault=%b want ffffffde 0", r_rd, r_flt); end
        issue(1'b0, F3_HU, 32'h13FE, 32'h0);
        checks++; if (r_rd !== 32'h0000_DEAD) begin errors++; $display("FAIL lhu_last got %h want 0000dead", r_rd); end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, F3_W, 32'h1004, 32'hCAFE_F00D);
        checks++; if (r_lat != 2 || r_nbusy != 0) begin errors++; $display("FAIL b2b_sw got lat=%0d ready_busy=%0d want 2 0", r_lat, r_nbusy); end
        issue(1'b0, F3_W, 32'h1004, 32'h0);
        checks++; if (r_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_resp got %b want 1", r_rdy); end
        checks++; if (r_rd !== 32'hCAFE_F00D || r_lat != 2 || r_nbusy != 0) begin errors++; $display("FAIL b2b_lw got %h lat=%0d ready_busy=%0d want cafef00d 2 0", r_rd, r_lat, r_nbusy); end
        @(posedge clk); #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_resp_pulse got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_reset_mid_rmw;
        int nwr = 0, nv = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_H; bus.req_addr = 32'h1006; bus.req_wdata = 32'h0000_1111;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_read !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL rmw_rd_state got rd=%b ready=%b want 1 0", bus.mem_read, bus.req_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_outputs got rd=%b wr=%b wdata=%h want 0 0 0", bus.mem_read, bus.mem_write, bus.mem_wdata); end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_fault !== 1'b0 || bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_outputs got v=%b f=%b d=%h want 0 0 0", bus.resp_valid, bus.resp_fault, bus.resp_rdata); end
        repeat (3) begin
            @(negedge clk); nwr += int'(bus.mem_write); nv += int'(bus.resp_valid);
        end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", bus.req_ready); end
        repeat (3) begin
            @(negedge clk); nwr += int'(bus.mem_write); nv += int'(bus.resp_valid);
        end
        checks++; if (nwr != 0 || nv != 0) begin errors++; $display("FAIL rst_abandon got writes=%0d resps=%0d want 0 0", nwr, nv); end
        issue(1'b0, F3_W, 32'h1004, 32'h0);
        checks++; if (r_rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_mem_unchanged got %h want cafef00d", r_rd); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_rmw_store;
        test_fault;
        test_boundary;
        test_back_to_back;
        test_reset_mid_rmw;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
